// File: rtl/mips_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants and types for the multicycle MIPS control slice:
//   - opcode / funct encodings of the supported instruction subset
//   - ALU control codes driven towards the datapath ALU
//   - ALU B-operand and PC-source mux encodings
//   - 4-bit state enumeration of the control sequencer
// ----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    // True for every opcode the sequencer knows how to dispatch; R-type
    // legality additionally depends on the funct field.
    function automatic logic isKnownOp(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: isKnownOp = 1'b1;
            default:                                             isKnownOp = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ----------------------------------------------------------------------------
// mc_aludec
// Combinational R-type funct decoder.
//   i_funct      : funct field (instr[5:0])
//   o_aluControl : ALU operation code for the datapath
//   o_illegal    : funct is not one of the supported R-type operations
// ----------------------------------------------------------------------------
module mc_aludec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_aluControl,
    output logic       o_illegal
);

    // Map each supported funct onto its ALU code; anything else is flagged.
    always_comb begin
        o_aluControl = ALU_AND;
        o_illegal    = 1'b0;
        case (i_funct)
            FN_ADD:  o_aluControl = ALU_ADD;
            FN_SUB:  o_aluControl = ALU_SUB;
            FN_AND:  o_aluControl = ALU_AND;
            FN_OR:   o_aluControl = ALU_OR;
            FN_SLT:  o_aluControl = ALU_SLT;
            default: o_illegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Multicycle control sequencer for a shared-memory MIPS datapath.
// Inputs : clk, reset (async, active-low), op/funct from the instruction
//          register, ALU zero flag, mem_ready handshake.
// Outputs: memory request/write/address-select, IR and PC enables, register
//          file write controls, ALU operand/operation selects, PC source,
//          sticky illegal-instruction flag err, retired count instret.
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ILLEGAL_HALT = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcen,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             err,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [5:0]       r_funct;
    logic             r_err;
    logic [CNT_W-1:0] r_instret;

    logic [5:0]       w_decFunct;
    logic [2:0]       w_decAluControl;
    logic             w_decIllegal;
    logic             w_instrIllegal;

    logic             w_memReq;
    logic             w_memWrite;
    logic             w_irWrite;
    logic             w_pcEn;
    logic             w_regWrite;

    // The decoder sees the live IR funct while dispatching, and the latched
    // funct afterwards so EXECUTE is immune to later IR changes.
    assign w_decFunct = (r_state == S_DECODE) ? funct : r_funct;

    mc_aludec u_aludec (
        .i_funct      (w_decFunct),
        .o_aluControl (w_decAluControl),
        .o_illegal    (w_decIllegal)
    );

    assign w_instrIllegal = !isKnownOp(op) || ((op == OP_RTYPE) && w_decIllegal);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Instruction fields are captured in DECODE for use by later states.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op    <= '0;
            r_funct <= '0;
        end else if (r_state == S_DECODE) begin
            r_op    <= op;
            r_funct <= funct;
        end
    end

    // Sticky error flag and retired count; any return to FETCH from another
    // state marks the end of one instruction, including a skipped illegal one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err     <= 1'b0;
            r_instret <= '0;
        end else begin
            if ((r_state == S_DECODE) && w_instrIllegal) begin
                r_err <= 1'b1;
            end
            if ((r_state != S_FETCH) && (w_next == S_FETCH)) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_instrIllegal) begin
                    w_next = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW:   w_next = S_MEMADR;
                        OP_RTYPE:       w_next = S_EXECUTE;
                        OP_BEQ, OP_BNE: w_next = S_BRANCH;
                        OP_ADDI:        w_next = S_ADDIEX;
                        OP_J:           w_next = S_JUMP;
                        default:        w_next = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  w_next = (r_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   if (mem_ready) w_next = S_FETCH;
            S_EXECUTE: w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_ADDIEX:  w_next = S_ADDIWB;
            S_ADDIWB:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH;
        endcase
    end

    // Output decode: Moore per state, except the FETCH enables wait for
    // mem_ready and the branch PC enable follows zero (inverted for bne).
    always_comb begin
        w_memReq   = 1'b0;
        w_memWrite = 1'b0;
        w_irWrite  = 1'b0;
        w_pcEn     = 1'b0;
        w_regWrite = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_REG;
        pcsrc      = PCSRC_ALU;
        alucontrol = ALU_AND;
        case (r_state)
            S_FETCH: begin
                w_memReq   = 1'b1;
                w_irWrite  = mem_ready;
                w_pcEn     = mem_ready;
                alusrcb    = SRCB_FOUR;
                alucontrol = ALU_ADD;
            end
            S_DECODE: begin
                alusrcb    = SRCB_IMMSH;
                alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                w_memReq = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                w_regWrite = 1'b1;
                memtoreg   = 1'b1;
            end
            S_MEMWR: begin
                w_memReq   = 1'b1;
                w_memWrite = 1'b1;
                iord       = 1'b1;
            end
            S_EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = w_decAluControl;
            end
            S_ALUWB: begin
                w_regWrite = 1'b1;
                regdst     = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = PCSRC_ALUOUT;
                w_pcEn     = zero ^ (r_op == OP_BNE);
            end
            S_ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = SRCB_IMM;
                alucontrol = ALU_ADD;
            end
            S_ADDIWB: begin
                w_regWrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc  = PCSRC_JUMP;
                w_pcEn = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Strobes are gated by reset directly so an access in flight is dropped
    // the moment reset asserts, without waiting for a clock edge.
    assign mem_req  = w_memReq   & reset;
    assign memwrite = w_memWrite & reset;
    assign irwrite  = w_irWrite  & reset;
    assign pcen     = w_pcEn     & reset;
    assign regwrite = w_regWrite & reset;
    assign err      = r_err;
    assign instret  = r_instret;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Table-driven bench for the multicycle control sequencer, followed by a
// hand-written sequence for reset asserted in the middle of a store.
// ----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_BNE   = 6'b000101;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;
    localparam logic [5:0] T_JUNK  = 6'b111111;
    localparam logic [5:0] T_SLT   = 6'b101010;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        memReady;
    logic        memReq;
    logic        memWrite;
    logic        iord;
    logic        irWrite;
    logic        pcEn;
    logic        regWrite;
    logic        regDst;
    logic        memToReg;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic [1:0]  pcSrc;
    logic [2:0]  aluControl;
    logic        err;
    logic [31:0] instret;

    typedef struct {
        logic        rstN;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [15:0] expOut;
        logic        expErr;
        logic [31:0] expCnt;
    } vec_t;

    vec_t vecs[64];
    int   nVec;
    int   total;
    int   bad;

    mips_multicycle_ctrl #(.ILLEGAL_HALT(1), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (memReady),
        .mem_req    (memReq),
        .memwrite   (memWrite),
        .iord       (iord),
        .irwrite    (irWrite),
        .pcen       (pcEn),
        .regwrite   (regWrite),
        .regdst     (regDst),
        .memtoreg   (memToReg),
        .alusrca    (aluSrcA),
        .alusrcb    (aluSrcB),
        .pcsrc      (pcSrc),
        .alucontrol (aluControl),
        .err        (err),
        .instret    (instret)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pack control outputs in a fixed order for single-compare checking.
    function automatic logic [15:0] mk(input logic mr, input logic mw, input logic io,
                                       input logic irw, input logic pe, input logic rw,
                                       input logic rd, input logic mtr, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] ps,
                                       input logic [2:0] ac);
        mk = {mr, mw, io, irw, pe, rw, rd, mtr, sa, sb, ps, ac};
    endfunction

    function automatic logic [15:0] actualOut();
        actualOut = {memReq, memWrite, iord, irWrite, pcEn, regWrite, regDst, memToReg,
                     aluSrcA, aluSrcB, pcSrc, aluControl};
    endfunction

    task automatic addVec(input logic r, input logic [5:0] o, input logic [5:0] f,
                          input logic z, input logic rd, input logic [15:0] eo,
                          input logic ee, input logic [31:0] ec);
        vecs[nVec].rstN   = r;
        vecs[nVec].op     = o;
        vecs[nVec].funct  = f;
        vecs[nVec].zero   = z;
        vecs[nVec].rdy    = rd;
        vecs[nVec].expOut = eo;
        vecs[nVec].expErr = ee;
        vecs[nVec].expCnt = ec;
        nVec++;
    endtask

    task automatic applyStimulus(input int idx);
        reset    = vecs[idx].rstN;
        op       = vecs[idx].op;
        funct    = vecs[idx].funct;
        zero     = vecs[idx].zero;
        memReady = vecs[idx].rdy;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] expOut,
                               input logic expErr, input logic [31:0] expCnt);
        total++;
        if (actualOut() !== expOut) begin
            bad++;
            $display("[TB] FAIL %s ctrl: got %b want %b", name, actualOut(), expOut);
        end
        total++;
        if (err !== expErr) begin
            bad++;
            $display("[TB] FAIL %s err: got %b want %b", name, err, expErr);
        end
        total++;
        if (instret !== expCnt) begin
            bad++;
            $display("[TB] FAIL %s instret: got %0d want %0d", name, instret, expCnt);
        end
    endtask

    initial begin
        logic [15:0] oFetch;
        logic [15:0] oFetchWait;
        logic [15:0] oDecode;
        logic [15:0] oAddr;
        logic [15:0] oMemRd;
        logic [15:0] oMemWb;
        logic [15:0] oMemWr;
        logic [15:0] oBrTaken;
        logic [15:0] oBrNot;
        logic [15:0] oIdle;
        logic [15:0] oFetchRst;

        total = 0;
        bad   = 0;
        nVec  = 0;

        oFetch     = mk(1,0,0,1,1,0,0,0,0,2'b01,2'b00,3'b010);
        oFetchWait = mk(1,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010);
        oFetchRst  = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010);
        oDecode    = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010);
        oAddr      = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010);
        oMemRd     = mk(1,0,1,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        oMemWb     = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000);
        oMemWr     = mk(1,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000);
        oBrTaken   = mk(0,0,0,0,1,0,0,0,1,2'b00,2'b01,3'b110);
        oBrNot     = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110);
        oIdle      = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000);

        // Reset, then lw with ready memory
        addVec(0, T_LW,   0, 0, 1, oFetchRst, 0, 0);
        addVec(1, T_LW,   0, 0, 1, oFetch,    0, 0);
        addVec(1, T_LW,   0, 0, 1, oDecode,   0, 0);
        addVec(1, T_JUNK, 0, 0, 1, oAddr,     0, 0);
        addVec(1, T_JUNK, 0, 0, 1, oMemRd,    0, 0);
        addVec(1, T_JUNK, 0, 0, 1, oMemWb,    0, 0);
        // sw with three not-ready cycles in MEMWR
        addVec(1, T_SW,   0, 0, 1, oFetch,    0, 1);
        addVec(1, T_SW,   0, 0, 1, oDecode,   0, 1);
        addVec(1, T_JUNK, 0, 0, 1, oAddr,     0, 1);
        addVec(1, T_JUNK, 0, 0, 0, oMemWr,    0, 1);
        addVec(1, T_JUNK, 0, 0, 0, oMemWr,    0, 1);
        addVec(1, T_JUNK, 0, 0, 0, oMemWr,    0, 1);
        addVec(1, T_JUNK, 0, 0, 1, oMemWr,    0, 1);
        // beq taken / not taken, bne taken / not taken
        addVec(1, T_BEQ,  0, 0, 1, oFetch,    0, 2);
        addVec(1, T_BEQ,  0, 0, 1, oDecode,   0, 2);
        addVec(1, T_JUNK, 0, 1, 1, oBrTaken,  0, 2);
        addVec(1, T_BEQ,  0, 0, 1, oFetch,    0, 3);
        addVec(1, T_BEQ,  0, 0, 1, oDecode,   0, 3);
        addVec(1, T_JUNK, 0, 0, 1, oBrNot,    0, 3);
        addVec(1, T_BNE,  0, 0, 1, oFetch,    0, 4);
        addVec(1, T_BNE,  0, 0, 1, oDecode,   0, 4);
        addVec(1, T_JUNK, 0, 0, 1, oBrTaken,  0, 4);
        addVec(1, T_BNE,  0, 0, 1, oFetch,    0, 5);
        addVec(1, T_BNE,  0, 0, 1, oDecode,   0, 5);
        addVec(1, T_JUNK, 0, 1, 1, oBrNot,    0, 5);
        // Fetch wait, then slt
        addVec(1, T_RTYPE, T_SLT, 0, 0, oFetchWait, 0, 6);
        addVec(1, T_RTYPE, T_SLT, 0, 1, oFetch,     0, 6);
        addVec(1, T_RTYPE, T_SLT, 0, 1, oDecode,    0, 6);
        addVec(1, T_JUNK,  0,     0, 1, mk(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b111), 0, 6);
        addVec(1, T_JUNK,  0,     0, 1, mk(0,0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000), 0, 6);
        // j then addi
        addVec(1, T_J,    0, 0, 1, oFetch,    0, 7);
        addVec(1, T_J,    0, 0, 1, oDecode,   0, 7);
        addVec(1, T_JUNK, 0, 0, 1, mk(0,0,0,0,1,0,0,0,0,2'b00,2'b10,3'b000), 0, 7);
        addVec(1, T_ADDI, 0, 0, 1, oFetch,    0, 8);
        addVec(1, T_ADDI, 0, 0, 1, oDecode,   0, 8);
        addVec(1, T_JUNK, 0, 0, 1, oAddr,     0, 8);
        addVec(1, T_JUNK, 0, 0, 1, mk(0,0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000), 0, 8);
        // Illegal R-type funct halts the core
        addVec(1, T_RTYPE, 0, 0, 1, oFetch,  0, 9);
        addVec(1, T_RTYPE, 0, 0, 1, oDecode, 0, 9);
        addVec(1, T_JUNK,  0, 0, 1, oIdle,   1, 9);
        addVec(1, T_LW,    0, 0, 1, oIdle,   1, 9);
        addVec(1, T_LW,    0, 0, 1, oIdle,   1, 9);

        reset    = 1'b0;
        op       = '0;
        funct    = '0;
        zero     = 1'b0;
        memReady = 1'b0;

        for (int i = 0; i < nVec; i++) begin
            @(negedge clk);
            applyStimulus(i);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].expErr, vecs[i].expCnt);
        end

        // Reset asserted mid-cycle while a store is waiting on memory
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("haltReset", oFetchRst, 1'b0, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        op       = T_SW;
        memReady = 1'b1;
        #1;
        checkOutput("swFetch", oFetch, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("swDecode", oDecode, 1'b0, 32'd0);
        @(negedge clk);
        op = T_JUNK;
        #1;
        checkOutput("swAddr", oAddr, 1'b0, 32'd0);
        @(negedge clk);
        memReady = 1'b0;
        #1;
        checkOutput("swWait", oMemWr, 1'b0, 32'd0);
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (memWrite !== 1'b0 || memReq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midReset strobes: got memwrite=%b mem_req=%b want 0 0", memWrite, memReq);
        end
        checkOutput("midReset", oFetchRst, 1'b0, 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        memReady = 1'b0;
        #1;
        checkOutput("afterRelease", oFetchWait, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle control FSM for the MIPS core. It replaces single-cycle decoding with a state sequencer that drives a shared-memory datapath: one unified memory port, an instruction register, and the ALU reused for PC+4, branch target and effective address. Memory accesses use a req/ready handshake, so the core can sit behind the cache/AXI path. It also reports illegal opcodes and keeps a retired-instruction count.

Parameters:
ILLEGAL_HALT, 1, 1: illegal op/funct enters HALT and asserts err; 0: illegal instruction retires as a NOP.
CNT_W, 32, width of the instret counter.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-low (state cleared while reset==0)
op  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory accepted/completed the current access
mem_req  output  1  memory access request
memwrite  output  1  write strobe, valid with mem_req
iord  output  1  0: address=PC, 1: address=ALUOut
irwrite  output  1  load instruction register
pcen  output  1  PC register enable
regwrite  output  1  register file write
regdst  output  1  0: rt, 1: rd
memtoreg  output  1  0: ALUOut, 1: memory data register
alusrca  output  1  0: PC, 1: register A
alusrcb  output  2  00: B, 01: const 4, 10: sign-extended imm, 11: sign-extended imm<<2
pcsrc  output  2  00: ALU result, 01: ALUOut (branch target), 10: jump target
alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
err  output  1  sticky illegal-instruction flag
instret  output  CNT_W  retired-instruction count

Behaviour:
- Reset (reset==0, asynchronous):
  - state=FETCH, instret=0, err=0, latched op/funct=0.
  - All strobes (mem_req, memwrite, irwrite, pcen, regwrite) are forced 0 combinationally while reset is low.
  - Reset mid-access drops memwrite immediately.
- Outputs are Moore-decoded from state. Exceptions: pcen and irwrite are qualified by mem_ready/zero as listed below.
- States, outputs and transitions (unlisted outputs are 0):
  - FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. If mem_ready: irwrite=1, pcen=1, go to DECODE; else hold.
  - DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Latch op/funct. Dispatch:
    - 100011/101011 -> MEMADR
    - 000000 with supported funct -> EXECUTE
    - 000100/000101 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - anything else is illegal.
  - MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_req=1, iord=1. Go to MEMWB on mem_ready.
  - MEMWB: regwrite=1, regdst=0, memtoreg=1. Go to FETCH.
  - MEMWR: mem_req=1, memwrite=1, iord=1, held until mem_ready. Then go to FETCH.
  - EXECUTE: alusrca=1, alusrcb=00, alucontrol from latched funct. Go to ALUWB.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0. Go to FETCH.
  - BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen = zero XOR (latched op==000101). Go to FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, add. Go to ADDIWB.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0. Go to FETCH.
  - JUMP: pcsrc=10, pcen=1. Go to FETCH.
  - HALT: all strobes 0, err=1. Exit only via reset.
- Illegal instruction in DECODE:
  - ILLEGAL_HALT=1: go to HALT, err set.
  - ILLEGAL_HALT=0: go to FETCH, err set, instret increments.
- instret increments by 1 on every transition into FETCH from a terminal state. It wraps modulo 2^CNT_W and does not increment on FETCH wait cycles.
- Latency:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq/bne/j = 3 cycles
  - each mem_ready-low cycle in FETCH/MEMRD/MEMWR adds 1.
- mem_ready while mem_req=0 is ignored. mem_req/iord/memwrite remain stable until the handshake completes.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - alucontrol codes
  - alusrcb/pcsrc encodings
  - state enum (4-bit)
- One sub-module, mc_aludec: combinational funct -> alucontrol with an illegal flag. It is used in DECODE (legality) and EXECUTE (drive).

Test Plan:
- Reset release, mem_ready=1, op=100011 -> FETCH, DECODE, MEMADR, MEMRD, MEMWB. Check: pcen and irwrite high cycle 1, regwrite+memtoreg cycle 5, instret=1.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite and iord held 4 cycles, no regwrite, FETCH next, instret=1.
- beq with zero=1 -> pcen=1, pcsrc=01. beq zero=0 -> pcen=0. bne zero=0 -> pcen=1. bne zero=1 -> pcen=0.
- R-type funct=101010 -> EXECUTE alucontrol=111, ALUWB regdst=1. funct=000000 with ILLEGAL_HALT=1 -> HALT, err=1, no further mem_req.
- j then addi -> JUMP pcsrc=10 pcen=1, ADDIWB regdst=0. After 2 instructions instret=2.
- Assert reset during MEMWR wait -> memwrite=0 in the same cycle. After release: state FETCH, instret=0, err=0.
